csr_tx_fifo: RTL and testbench

//  CSR-mapped, buffered byte-output channel; generalises the single-CSR debug console.
//  A write to DATA_ADDR pushes a character into a DEPTH-entry FIFO.
//  The FIFO drains over a valid/ready byte stream to a UART or simulation sink.

---
 rtl/csr_tx_fifo.sv | 133 +++++++++++++
 tb/tb_csr_tx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_tx_fifo.sv
// CSR-mapped byte output channel: DATA pushes into a FIFO drained over valid/ready,
// STAT reports FIFO state and defers an exit/fail request until the FIFO is empty.
module csr_tx_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [11:0] DATA_ADDR  = 12'h7C0,
   parameter logic [11:0] STAT_ADDR  = 12'h7C1
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [11:0]       cadr_i,
   output logic              cvalid_o,
   output logic [63:0]       cdat_o,
   input  logic [63:0]       cdat_i,
   input  logic              coe_i,
   input  logic              cwe_i,
   output logic              tx_valid_o,
   output logic [DATA_W-1:0] tx_data_o,
   input  logic              tx_ready_i,
   output logic              exit_o,
   output logic              fail_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PEND,
      S_DONE
   } state_e;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  fail_pend_q, fail_pend_d;
   state_e                state_q, state_d;

   logic sel_data, sel_stat;
   logic empty, full;
   logic push_req, push, pop, ovf_evt;
   logic exit_req;

   assign sel_data = (cadr_i == DATA_ADDR);
   assign sel_stat = (cadr_i == STAT_ADDR);
   assign cvalid_o = sel_data | sel_stat;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   assign pop      = ~empty & tx_ready_i;
   assign push_req = sel_data & cwe_i;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push     = push_req & (~full | pop);
   assign ovf_evt  = push_req & full & ~pop;
   assign exit_req = sel_stat & cwe_i & cdat_i[3];

   assign tx_valid_o = ~empty;
   assign tx_data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign exit_o     = (state_q == S_DONE);
   assign fail_o     = exit_o & fail_pend_q;

   always_comb begin
      cdat_o = 64'h0;
      if (sel_stat) begin
         cdat_o = {16'h0, 16'(count_q), 24'h0, 3'b0,
                   fail_o, exit_o, ovf_q, full, empty};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (ovf_evt)
         ovf_d = 1'b1;
      else if (sel_stat & coe_i)
         ovf_d = 1'b0;
   end

   always_comb begin
      state_d     = state_q;
      fail_pend_d = fail_pend_q;
      unique case (state_q)
         S_IDLE: begin
            if (exit_req) begin
               state_d     = S_PEND;
               fail_pend_d = cdat_i[4];
            end
         end
         S_PEND: begin
            if (empty & ~push_req) state_d = S_DONE;
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         fail_pend_q <= 1'b0;
         state_q     <= S_IDLE;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         fail_pend_q <= fail_pend_d;
         state_q     <= state_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= cdat_i[DATA_W-1:0];
   end

endmodule

// File: tb/tb_csr_tx_fifo.sv
// Scoreboard bench for csr_tx_fifo: stimulus queues expected bytes,
// a forked monitor pops and compares on every stream handshake.
module tb_csr_tx_fifo;

   localparam logic [11:0] DA = 12'h7C0;
   localparam logic [11:0] SA = 12'h7C1;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic [11:0] cadr_i;
   logic        cvalid_o;
   logic [63:0] cdat_o;
   logic [63:0] cdat_i;
   logic        coe_i;
   logic        cwe_i;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i;
   logic        exit_o;
   logic        fail_o;

   int nvec = 0;
   int nerr = 0;
   logic [7:0] sb [$];

   csr_tx_fifo #(
      .DATA_W(8),
      .DEPTH_LOG2(4),
      .DATA_ADDR(DA),
      .STAT_ADDR(SA)
   ) dut (
      .clk_i(clk),
      .reset_ni(reset_ni),
      .cadr_i(cadr_i),
      .cvalid_o(cvalid_o),
      .cdat_o(cdat_o),
      .cdat_i(cdat_i),
      .coe_i(coe_i),
      .cwe_i(cwe_i),
      .tx_valid_o(tx_valid_o),
      .tx_data_o(tx_data_o),
      .tx_ready_i(tx_ready_i),
      .exit_o(exit_o),
      .fail_o(fail_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
      cadr_i = a;
      cdat_i = d;
      cwe_i  = 1'b1;
      @(posedge clk);
      #1;
      cwe_i  = 1'b0;
      cadr_i = 12'h0;
      cdat_i = 64'h0;
   endtask

   task automatic push(input logic [7:0] b);
      sb.push_back(b);
      csr_wr(DA, {56'hABCDEF_0123_4567, b});
   endtask

   task automatic stat_rd(input string nm, input logic c,
                          input logic [63:0] e);
      cadr_i = SA;
      coe_i  = c;
      #1;
      chk(nm, cdat_o, e);
      @(posedge clk);
      #1;
      coe_i  = 1'b0;
      cadr_i = 12'h0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      tx_ready_i = 1'b1;
      while ((sb.size() != 0 || tx_valid_o) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      tx_ready_i = 1'b0;
      chk(nm, 64'(n < 300), 64'h1);
   endtask

   initial begin
      logic [7:0] e;
      bit seen;
      reset_ni   = 1'b0;
      cadr_i     = 12'h0;
      cdat_i     = 64'h0;
      coe_i      = 1'b0;
      cwe_i      = 1'b0;
      tx_ready_i = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (reset_ni && tx_valid_o && tx_ready_i) begin
               if (sb.size() == 0) begin
                  chk("unexpected beat", {56'h0, tx_data_o}, 64'h0);
                  chk("beat with empty scoreboard", 64'h1, 64'h0);
               end else begin
                  e = sb.pop_front();
                  chk("stream byte", {56'h0, tx_data_o}, {56'h0, e});
               end
            end
         end
      join_none

      // 1: reset state and decode
      repeat (2) @(posedge clk);
      #1;
      chk("rst tx_valid", 64'(tx_valid_o), 64'h0);
      chk("rst tx_data", {56'h0, tx_data_o}, 64'h0);
      chk("rst exit", 64'(exit_o), 64'h0);
      reset_ni = 1'b1;
      @(posedge clk);
      #1;
      stat_rd("t1 stat", 1'b0, 64'h1);
      cadr_i = DA;
      #1;
      chk("data cvalid", 64'(cvalid_o), 64'h1);
      chk("data rd", cdat_o, 64'h0);
      cadr_i = 12'h7C2;
      #1;
      chk("other cvalid", 64'(cvalid_o), 64'h0);
      chk("other rd", cdat_o, 64'h0);
      cadr_i = 12'h0;

      // 2: three characters, ordered drain
      push(8'h41);
      push(8'h42);
      push(8'h43);
      chk("t2 valid", 64'(tx_valid_o), 64'h1);
      chk("t2 head held", {56'h0, tx_data_o}, 64'h41);
      stat_rd("t2 count3", 1'b0, 64'h0000_0003_0000_0000);
      drain("t2 drain");
      stat_rd("t2 count0", 1'b0, 64'h1);

      // 3: overflow on the 17th write
      for (int i = 0; i < 17; i++) begin
         if (i < 16) push(8'h50 + 8'(i));
         else csr_wr(DA, 64'h5F5F);
      end
      stat_rd("t3 full ovf", 1'b0, 64'h0000_0010_0000_0006);
      stat_rd("t3 coe0", 1'b0, 64'h0000_0010_0000_0006);
      stat_rd("t3 coe1", 1'b1, 64'h0000_0010_0000_0006);
      stat_rd("t3 ovf clr", 1'b0, 64'h0000_0010_0000_0002);

      // 4: write to a full FIFO while the head pops
      tx_ready_i = 1'b1;
      sb.push_back(8'h5A);
      csr_wr(DA, 64'h5A);
      tx_ready_i = 1'b0;
      stat_rd("t4 full no ovf", 1'b0, 64'h0000_0010_0000_0002);
      drain("t4 drain");

      // 5: deferred exit with fail
      push(8'h61);
      push(8'h62);
      push(8'h63);
      push(8'h64);
      csr_wr(SA, 64'h18);
      chk("t5 exit pend", 64'(exit_o), 64'h0);
      tx_ready_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (!tx_valid_o) begin
            seen = 1'b1;
            break;
         end
         chk("t5 exit early", 64'(exit_o), 64'h0);
      end
      chk("t5 drained", 64'(seen), 64'h1);
      chk("t5 exit at empty", 64'(exit_o), 64'h0);
      @(posedge clk);
      #1;
      tx_ready_i = 1'b0;
      chk("t5 exit", 64'(exit_o), 64'h1);
      chk("t5 fail", 64'(fail_o), 64'h1);
      csr_wr(SA, 64'h08);
      chk("t5 first wins", 64'(fail_o), 64'h1);
      push(8'h7E);
      drain("t5 done drain");
      stat_rd("t5 stat", 1'b0, 64'h19);

      // 6: reset mid-drain
      for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
      tx_ready_i = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset_ni   = 1'b0;
      tx_ready_i = 1'b0;
      #1;
      chk("t6 left", 64'(sb.size()), 64'h3);
      sb.delete();
      chk("t6 valid", 64'(tx_valid_o), 64'h0);
      chk("t6 exit", 64'(exit_o), 64'h0);
      chk("t6 fail", 64'(fail_o), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_ni = 1'b1;
      @(posedge clk);
      #1;
      stat_rd("t6 stat", 1'b0, 64'h1);
      chk("t6 sb empty", 64'(sb.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
